csnc_enc_k3_l12: RTL and testbench

CSNC_ENC_K3_L12 -- requirements
Module: csnc_enc_k3_l12

---
 rtl/csnc_pkg.sv | 38 +++
 rtl/csnc_parity_acc.sv | 52 +++++
 rtl/csnc_enc_k3_l12.sv | 153 +++++++++++++++
 tb/tb_csnc_enc_k3_l12.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csnc_pkg.sv
// Shared definitions for the CSNC (K=3, L=12) encoder and decoder.
//   L, K, N            : symbol width, data symbols per frame, coded symbols
//   R01, R02, R11, R12 : rotation exponents of d1/d2 in parity p0/p1
//   role_e             : role of a coded symbol on the output stream
//   state_e            : encoder FSM states
//   rot()              : cyclic rotation, rot(v,k)[r] = v[(r-k) mod L]
package csnc_pkg;

  localparam int L = 12;
  localparam int K = 3;
  localparam int N = 5;

  localparam int unsigned R01 = 1;
  localparam int unsigned R02 = 2;
  localparam int unsigned R11 = 5;
  localparam int unsigned R12 = 10;

  typedef enum logic [2:0] {
    ROLE_D0 = 3'd0,
    ROLE_D1 = 3'd1,
    ROLE_D2 = 3'd2,
    ROLE_P0 = 3'd3,
    ROLE_P1 = 3'd4
  } role_e;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  // Bit r of the result takes bit (r-k) mod L of v: a left rotation by k.
  function automatic logic [L-1:0] rot(input logic [L-1:0] v, input int unsigned k);
    int unsigned s;
    s = k % L;
    return (v << s) | (v >> (L - s));
  endfunction

endpackage

// File: rtl/csnc_parity_acc.sv
// Running p0/p1 parity accumulators.
//   clk, rst_n : clock, asynchronous active-low reset
//   symbol     : data symbol being accepted
//   index      : its position in the frame (0=d0, 1=d1, 2=d2)
//   clear      : drop the previous residue (asserted with d0)
//   enable     : symbol is accepted this cycle
//   p0, p1     : accumulated parities, complete the cycle after d2 is accepted
module csnc_parity_acc
  import csnc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [L-1:0] symbol,
  input  logic [1:0]   index,
  input  logic         clear,
  input  logic         enable,
  output logic [L-1:0] p0,
  output logic [L-1:0] p1
);

  logic [L-1:0] c0;
  logic [L-1:0] c1;

  // Contribution of the current symbol to each parity.
  always_comb begin
    c0 = symbol;
    c1 = symbol;
    case (index)
      2'd1: begin
        c0 = rot(symbol, R01);
        c1 = rot(symbol, R11);
      end
      2'd2: begin
        c0 = rot(symbol, R02);
        c1 = rot(symbol, R12);
      end
      default: ;
    endcase
  end

  // With clear the accumulator restarts from this symbol's contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= '0;
      p1 <= '0;
    end else if (enable) begin
      p0 <= (clear ? '0 : p0) ^ c0;
      p1 <= (clear ? '0 : p1) ^ c1;
    end
  end

endmodule

// File: rtl/csnc_enc_k3_l12.sv
// CSNC systematic encoder: 3 data symbols in, d0,d1,d2,p0,p1 out.
// Optional build macro: CSNC_ERASURE_INJECT_EN adds erase_mask[4:0], sampled
// with d0; set bits suppress those roles (a mask whose popcount is not 2 is
// replaced by 5'b11000 and flagged on frame_err).
//   aclk, aresetn                 : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast : data symbols d0,d1,d2 (tlast on d2)
//   m_axis_tdata/role/tvalid/tready/tlast : coded symbols with role tag
//   frame_err                     : one-cycle pulse on a mis-framed beat
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; once valid is raised, payload stays fixed until the transfer.
module csnc_enc_k3_l12 #(
  parameter int L = csnc_pkg::L,
  parameter int K = csnc_pkg::K
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [L-1:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [L-1:0] m_axis_tdata,
  output logic [2:0]   m_axis_role,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         frame_err
`ifdef CSNC_ERASURE_INJECT_EN
  ,
  input  logic [4:0]   erase_mask
`endif
);

  csnc_pkg::state_e state_q, state_d;

  logic [1:0]   beat_q;
  logic [2:0]   role_q;
  logic [L-1:0] d0_q, d1_q, d2_q;
  logic [L-1:0] p0, p1;
  logic [csnc_pkg::N-1:0] mask_q;
  logic         mask_err;
  logic         s_hs, m_hs, last_beat, emit;
  logic [2:0]   first_role, next_role;
  logic         has_next;

  assign emit          = (state_q == csnc_pkg::EMIT);
  // Held low during reset so nothing is accepted before the FSM is defined.
  assign s_axis_tready = aresetn && (state_q == csnc_pkg::COLLECT);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (beat_q == 2'(K - 1));

`ifdef CSNC_ERASURE_INJECT_EN
  logic mask_ok;
  assign mask_ok  = ($countones(erase_mask) == 2);
  assign mask_err = s_hs && (beat_q == 2'd0) && !mask_ok;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mask_q <= '0;
    end else if (s_hs && (beat_q == 2'd0)) begin
      mask_q <= mask_ok ? erase_mask : 5'b11000;
    end
  end
`else
  assign mask_q   = '0;
  assign mask_err = 1'b0;
`endif

  // Lowest unmasked role, and the next unmasked role above role_q.
  always_comb begin
    first_role = 3'd0;
    next_role  = 3'd0;
    has_next   = 1'b0;
    for (int i = csnc_pkg::N - 1; i >= 0; i--) begin
      if (!mask_q[3'(i)]) first_role = 3'(i);
    end
    for (int i = csnc_pkg::N - 1; i >= 0; i--) begin
      if (!mask_q[3'(i)] && (3'(i) > role_q)) begin
        next_role = 3'(i);
        has_next  = 1'b1;
      end
    end
  end

  csnc_parity_acc u_acc (
    .clk    (aclk),
    .rst_n  (aresetn),
    .symbol (s_axis_tdata),
    .index  (beat_q),
    .clear  (beat_q == 2'd0),
    .enable (s_hs),
    .p0     (p0),
    .p1     (p1)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      csnc_pkg::COLLECT: if (s_hs && last_beat) state_d = csnc_pkg::EMIT;
      csnc_pkg::EMIT:    if (m_hs && !has_next) state_d = csnc_pkg::COLLECT;
      default:           state_d = csnc_pkg::COLLECT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= csnc_pkg::COLLECT;
      beat_q  <= 2'd0;
      role_q  <= 3'd0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      if (s_hs) begin
        beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
        case (beat_q)
          2'd0:    d0_q <= s_axis_tdata;
          2'd1:    d1_q <= s_axis_tdata;
          default: d2_q <= s_axis_tdata;
        endcase
      end
      if (s_hs && last_beat) begin
        role_q <= first_role;
      end else if (m_hs) begin
        role_q <= next_role;
      end
    end
  end

  // Outputs come straight from held registers, so they stay put under stall.
  always_comb begin
    m_axis_tdata = '0;
    if (emit) begin
      case (role_q)
        3'd0:    m_axis_tdata = d0_q;
        3'd1:    m_axis_tdata = d1_q;
        3'd2:    m_axis_tdata = d2_q;
        3'd3:    m_axis_tdata = p0;
        3'd4:    m_axis_tdata = p1;
        default: m_axis_tdata = '0;
      endcase
    end
  end

  assign m_axis_tvalid = emit;
  assign m_axis_role   = emit ? role_q : 3'd0;
  assign m_axis_tlast  = emit && !has_next;

  // tlast must be low on beats 1-2 and high on beat 3.
  assign frame_err = (s_hs && (last_beat ? !s_axis_tlast : s_axis_tlast)) || mask_err;

endmodule

// File: tb/tb_csnc_enc_k3_l12.sv
// Self-checking bench for csnc_enc_k3_l12 (build with or without
// CSNC_ERASURE_INJECT_EN).
module tb_csnc_enc_k3_l12;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [11:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [11:0] m_axis_tdata;
  logic [2:0]  m_axis_role;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        frame_err;
`ifdef CSNC_ERASURE_INJECT_EN
  logic [4:0]  erase_mask = 5'b00011;
`endif

  logic [15:0] exp_q[$];
  int          cnt_q[$];
  int          total = 0;
  int          bad = 0;
  int          stall_left = 0;
  bit          rand_bp = 1'b0;

  typedef struct {
    logic [11:0] d0, d1, d2, p0, p1;
  } vec_t;

  always #5 aclk = ~aclk;

  csnc_enc_k3_l12 dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_role   (m_axis_role),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_err     (frame_err)
`ifdef CSNC_ERASURE_INJECT_EN
    ,
    .erase_mask    (erase_mask)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rotation: top half of {v,v} shifted left by k.
  function automatic logic [11:0] mrot(input logic [11:0] v, input int k);
    logic [23:0] w;
    w = {v, v} << k;
    return w[23:12];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat transferred.
  task automatic send_beat(input logic [11:0] d, input logic last, input logic exp_err);
    int waited = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      check("s_ready_timeout", 0, 1);
    end else begin
      check("frame_err", frame_err, exp_err);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] d0, d1, d2, p0, p1,
                            input logic [2:0] lasts, input logic [4:0] mask);
    logic [11:0] sym[5];
    logic [4:0]  eff;
    logic        mask_err;
    int          last_i;
    int          n;
    sym = '{d0, d1, d2, p0, p1};
    eff = '0;
    mask_err = 1'b0;
`ifdef CSNC_ERASURE_INJECT_EN
    eff = ($countones(mask) == 2) ? mask : 5'b11000;
    mask_err = ($countones(mask) != 2);
    erase_mask = mask;
`else
    if (mask != '0) $display("note: erase mask ignored in this build");
`endif
    send_beat(d0, lasts[0], lasts[0] | mask_err);
    send_beat(d1, lasts[1], lasts[1]);
    last_i = -1;
    n = 0;
    for (int i = 0; i < 5; i++) if (!eff[i]) begin last_i = i; n++; end
    for (int i = 0; i < 5; i++)
      if (!eff[i]) exp_q.push_back({3'(i), sym[i], 1'(i == last_i)});
    cnt_q.push_back(n);
    send_beat(d2, lasts[2], !lasts[2]);
    @(negedge aclk);
    check("latency_valid", m_axis_tvalid, 1);
    @(posedge aclk);
    #1;
  endtask

  task automatic send_rand_frame();
    logic [11:0] d0, d1, d2;
    d0 = 12'($urandom_range(0, 4095));
    d1 = 12'($urandom_range(0, 4095));
    d2 = 12'($urandom_range(0, 4095));
    send_frame(d0, d1, d2,
               d0 ^ mrot(d1, 1) ^ mrot(d2, 2),
               d0 ^ mrot(d1, 5) ^ mrot(d2, 10),
               ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b100,
               5'b00011);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Output sink: stalls role 3 for stall_left cycles, else ready or random.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (stall_left > 0 && m_axis_tvalid && m_axis_role == 3'd3) begin
        m_axis_tready = 1'b0;
        stall_left--;
      end else if (rand_bp) begin
        m_axis_tready = ($urandom_range(0, 3) != 0);
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial begin
    logic [15:0] snap, prev_snap, e;
    bit prev_stall, prev_hs, prev_last;
    int beats;
    prev_stall = 0; prev_hs = 0; prev_last = 0; prev_snap = '0; beats = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 0; prev_hs = 0; beats = 0;
        continue;
      end
      snap = {m_axis_role, m_axis_tdata, m_axis_tlast};
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_payload", snap, prev_snap);
      end
      if (prev_hs && !prev_last) check("no_bubble", m_axis_tvalid, 1);
      if (prev_hs && prev_last) check("s_ready_return", {s_axis_tready, m_axis_tvalid}, 2'b10);
      if (m_axis_tvalid) check("s_ready_low_in_emit", s_axis_tready, 0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("expected_queue_nonempty", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("coded_beat", snap, e);
        end
        beats++;
        if (m_axis_tlast) begin
          if (cnt_q.size() != 0) check("frame_beats", beats, cnt_q.pop_front());
          beats = 0;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_hs    = m_axis_tvalid && m_axis_tready;
      prev_last  = m_axis_tlast;
      prev_snap  = snap;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{12'h001, 12'h001, 12'h001, 12'h007, 12'h421};
    tbl[1] = '{12'h000, 12'h800, 12'h000, 12'h001, 12'h010};
    tbl[2] = '{12'h000, 12'h000, 12'h800, 12'h002, 12'h200};
    tbl[3] = '{12'hABC, 12'h000, 12'h000, 12'hABC, 12'hABC};
    tbl[4] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    tbl[5] = '{12'h000, 12'h003, 12'h000, 12'h006, 12'h060};
    tbl[6] = '{12'h0F0, 12'h0F0, 12'h000, 12'h110, 12'hEF1};

    // Reset values, with a valid beat offered during reset.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 12'h5A5;
    repeat (3) @(negedge aclk);
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_role, m_axis_tlast, frame_err}, 0);
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("s_ready_after_reset", s_axis_tready, 1);
    check("no_valid_in_collect", m_axis_tvalid, 0);
    @(posedge aclk);
    #1;

    // Table-driven frames, no backpressure.
    for (int i = 0; i < 7; i++)
      send_frame(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].p0, tbl[i].p1, 3'b100, 5'b00011);
    drain();

    // Role-3 beat stalled for 4 cycles.
    stall_left = 4;
    send_frame(12'h111, 12'h222, 12'h333,
               12'h111 ^ mrot(12'h222, 1) ^ mrot(12'h333, 2),
               12'h111 ^ mrot(12'h222, 5) ^ mrot(12'h333, 10), 3'b100, 5'b00011);
    drain();
    check("stall_consumed", stall_left, 0);

    // Reset pulse after d1 is accepted: partial frame discarded.
    send_beat(12'h123, 1'b0, 1'b0);
    send_beat(12'h456, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_s_ready", s_axis_tready, 0);
    check("midrst_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_role, m_axis_tlast, frame_err}, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_s_ready_release", s_axis_tready, 1);
    @(posedge aclk);
    #1;
    send_frame(12'h005, 12'h00A, 12'h300,
               12'h005 ^ mrot(12'h00A, 1) ^ mrot(12'h300, 2),
               12'h005 ^ mrot(12'h00A, 5) ^ mrot(12'h300, 10), 3'b100, 5'b00011);
    drain();

    // tlast early on beat 2 (and then on beat 3): error on beat 2 only.
    send_frame(12'h001, 12'h001, 12'h001, 12'h007, 12'h421, 3'b110, 5'b00011);
    // tlast missing on beat 3.
    send_frame(12'h000, 12'h800, 12'h000, 12'h001, 12'h010, 3'b000, 5'b00011);
    drain();

`ifdef CSNC_ERASURE_INJECT_EN
    send_frame(12'h001, 12'h001, 12'h001, 12'h007, 12'h421, 3'b100, 5'b00101);
    drain();
    send_frame(12'h001, 12'h001, 12'h001, 12'h007, 12'h421, 3'b100, 5'b00001);
    drain();
`endif

    // Random frames under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 20; i++) send_rand_frame();
    drain();
    rand_bp = 1'b0;
    check("frame_count_queue_empty", cnt_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
